// File: rtl/collective_switch_if.sv
// Flit-side bundle of the collective router crossbar: routed inputs with grant,
// registered direction outputs with downstream ready, and the drop counter.
interface collective_switch_if #(
  parameter int FLIT_SIZE = 82,
  parameter int M_IN      = 6,
  parameter int N_OUT     = 6,
  parameter int ROUTE_LEN = 3,
  parameter int CNT_W     = 16
);
  logic [M_IN*FLIT_SIZE-1:0]  in;
  logic [M_IN*ROUTE_LEN-1:0]  route_in;
  logic [M_IN-1:0]            in_valid;
  logic [M_IN-1:0]            in_avail;
  logic [N_OUT-1:0]           out_avail;
  logic [N_OUT-1:0]           out_valid;
  logic [N_OUT*FLIT_SIZE-1:0] out;
  logic [CNT_W-1:0]           drop_cnt;

  modport master (
    output in, route_in, in_valid, out_avail,
    input  in_avail, out_valid, out, drop_cnt
  );

  modport slave (
    input  in, route_in, in_valid, out_avail,
    output in_avail, out_valid, out, drop_cnt
  );
endinterface

// File: rtl/collective_switch.sv
// M_IN x N_OUT crossbar with per-output round-robin arbiters and one-entry output registers.
// Optional macro COLLECTIVE_REDUCE_EN: flagged flits to one output are summed into a single flit.
module collective_switch #(
  parameter int FLIT_SIZE = 82,
  parameter int M_IN      = 6,
  parameter int N_OUT     = 6,
  parameter int ROUTE_LEN = 3,
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  collective_switch_if.slave  sw
);
  localparam int PTR_W = (M_IN > 1) ? $clog2(M_IN) : 1;

  if (DATA_W >= FLIT_SIZE) begin : g_chk_data_w
    $error("DATA_W must be less than FLIT_SIZE");
  end
  if (N_OUT < 1 || N_OUT > 6) begin : g_chk_n_out
    $error("N_OUT must be in 1..6");
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PTR_W:0]   b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == M_IN - 1) ? '0 : p + 1'b1;
  endfunction

  logic [N_OUT-1:0]     r_vld_p1;
  logic [FLIT_SIZE-1:0] r_flit_p1 [N_OUT];
  logic [PTR_W-1:0]     r_ptr [N_OUT];
  logic [CNT_W-1:0]     r_drop_cnt;

  logic [FLIT_SIZE-1:0] w_flit [M_IN];
  logic [ROUTE_LEN-1:0] w_route [M_IN];
  logic [M_IN-1:0]      w_req [N_OUT];
  logic [M_IN-1:0]      w_gnt [N_OUT];
  logic [M_IN-1:0]      w_illegal;
  logic [M_IN-1:0]      w_avail;
  logic [PTR_W:0]       w_drops;
  logic [N_OUT-1:0]     w_can_load;
  logic [N_OUT-1:0]     w_any;
  logic [PTR_W-1:0]     w_win [N_OUT];
  logic [FLIT_SIZE-1:0] w_load_flit [N_OUT];

  // Stage p0: decode routes into per-output request vectors and drops
  always_comb begin
    logic hit;
    w_illegal = '0;
    w_drops   = '0;
    for (int j = 0; j < N_OUT; j++) w_req[j] = '0;
    for (int i = 0; i < M_IN; i++) begin
      w_flit[i]  = sw.in[i*FLIT_SIZE +: FLIT_SIZE];
      w_route[i] = sw.route_in[i*ROUTE_LEN +: ROUTE_LEN];
      hit = 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        w_req[j][i] = sw.in_valid[i] && (w_route[i] == ROUTE_LEN'(j + 1));
        hit = hit | w_req[j][i];
      end
      w_illegal[i] = sw.in_valid[i] & ~hit;
      if (w_illegal[i]) w_drops = w_drops + 1'b1;
    end
  end

  always_comb begin
    logic [PTR_W-1:0] idx;
    int               idx_i;
`ifdef COLLECTIVE_REDUCE_EN
    logic [DATA_W-1:0] sum;
    sum = '0;
`endif
    idx   = '0;
    idx_i = 0;
    for (int j = 0; j < N_OUT; j++) begin
      w_any[j]       = 1'b0;
      w_win[j]       = '0;
      w_gnt[j]       = '0;
      w_load_flit[j] = '0;
      w_can_load[j]  = !r_vld_p1[j] || sw.out_avail[j];
      for (int k = 0; k < M_IN; k++) begin
        idx_i = int'(r_ptr[j]) + k;
        if (idx_i >= M_IN) idx_i = idx_i - M_IN;
        idx = PTR_W'(idx_i);
        if (!w_any[j] && w_req[j][idx]) begin
          w_any[j] = 1'b1;
          w_win[j] = idx;
        end
      end
      if (w_any[j] && w_can_load[j]) begin
        w_gnt[j][w_win[j]] = 1'b1;
        w_load_flit[j]     = w_flit[w_win[j]];
`ifdef COLLECTIVE_REDUCE_EN
        // A flagged winner pulls in every flagged requester; unflagged ones wait
        if (w_flit[w_win[j]][FLIT_SIZE-1]) begin
          sum = '0;
          for (int i = 0; i < M_IN; i++) begin
            if (w_req[j][i] && w_flit[i][FLIT_SIZE-1]) begin
              w_gnt[j][i] = 1'b1;
              sum = sum + w_flit[i][DATA_W-1:0];
            end
          end
          w_load_flit[j][DATA_W-1:0] = sum;
        end
`endif
      end
    end
  end

  always_comb begin
    w_avail = w_illegal;
    for (int j = 0; j < N_OUT; j++) w_avail = w_avail | w_gnt[j];
    if (rst) w_avail = '0;
  end

  // Stage p1: output registers, arbiter pointers and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= '0;
      r_drop_cnt <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        r_ptr[j]     <= '0;
        r_flit_p1[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (|w_gnt[j]) begin
          r_vld_p1[j]  <= 1'b1;
          r_flit_p1[j] <= w_load_flit[j];
          r_ptr[j]     <= wrap_inc(w_win[j]);
        end else if (sw.out_avail[j]) begin
          r_vld_p1[j]  <= 1'b0;
        end
      end
      r_drop_cnt <= sat_add(r_drop_cnt, w_drops);
    end
  end

  always_comb begin
    sw.out = '0;
    for (int j = 0; j < N_OUT; j++) sw.out[j*FLIT_SIZE +: FLIT_SIZE] = r_flit_p1[j];
  end

  assign sw.in_avail  = w_avail;
  assign sw.out_valid = r_vld_p1;
  assign sw.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_collective_switch.sv
// Directed bench for collective_switch: forwarding, round-robin, backpressure,
// drops with saturation, mid-run reset and (build dependent) reduce handling.
module tb_collective_switch;
  localparam int F  = 82;
  localparam int MI = 6;
  localparam int NO = 6;
  localparam int RL = 3;
  localparam int DW = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  collective_switch_if #(.FLIT_SIZE(F), .M_IN(MI), .N_OUT(NO), .ROUTE_LEN(RL), .CNT_W(CW)) bus ();

  collective_switch #(.FLIT_SIZE(F), .M_IN(MI), .N_OUT(NO), .ROUTE_LEN(RL), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [F-1:0] f, input logic [RL-1:0] r);
    bus.in[i*F +: F]         = f;
    bus.route_in[i*RL +: RL] = r;
    bus.in_valid[i]          = 1'b1;
  endtask

  function automatic logic [F-1:0] out_j(input int j);
    return bus.out[j*F +: F];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.out_avail = '1;
    set_in(0, 82'h5, 3'd1);
    #1;
    total++; if (bus.in_avail !== 6'b0) begin bad++; $display("FAIL rst_in_avail got=%b want=%b", bus.in_avail, 6'b0); end
    step();
    total++; if (bus.out_valid !== 6'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=%b", bus.out_valid, 6'b0); end
    total++; if (bus.drop_cnt !== 16'h0) begin bad++; $display("FAIL rst_drop_cnt got=%h want=%h", bus.drop_cnt, 16'h0); end
    total++; if (bus.out !== '0) begin bad++; $display("FAIL rst_out got=%h want=0", bus.out); end
    bus.in_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [F-1:0] f;
    f = 82'h1_2345_6789_ABCD_EF00_00AA;
    bus.out_avail = 6'h3F;
    set_in(0, f, 3'd1);
    #1;
    total++; if (bus.in_avail !== 6'b000001) begin bad++; $display("FAIL single_avail got=%b want=%b", bus.in_avail, 6'b000001); end
    step();
    bus.in_valid = '0;
    total++; if (bus.out_valid !== 6'b000001) begin bad++; $display("FAIL single_vld got=%b want=%b", bus.out_valid, 6'b000001); end
    total++; if (out_j(0) !== f) begin bad++; $display("FAIL single_out0 got=%h want=%h", out_j(0), f); end
    total++; if (bus.out[NO*F-1:F] !== '0) begin bad++; $display("FAIL single_others got=%h want=0", bus.out[NO*F-1:F]); end
    step();
    total++; if (bus.out_valid !== 6'b0) begin bad++; $display("FAIL single_drain got=%b want=%b", bus.out_valid, 6'b0); end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 2, 5, 0, 2, 5};
    logic [F-1:0] fr [MI];
    for (int i = 0; i < MI; i++) fr[i] = 82'h100 + F'(i);
    bus.out_avail = 6'h3F;
    set_in(0, fr[0], 3'd3);
    set_in(2, fr[2], 3'd3);
    set_in(5, fr[5], 3'd3);
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (bus.in_avail !== 6'(1 << exp_order[c])) begin bad++; $display("FAIL rr_avail c=%0d got=%b want=%b", c, bus.in_avail, 6'(1 << exp_order[c])); end
      step();
      total++; if (bus.out_valid[2] !== 1'b1) begin bad++; $display("FAIL rr_vld c=%0d got=%b want=1", c, bus.out_valid[2]); end
      total++; if (out_j(2) !== fr[exp_order[c]]) begin bad++; $display("FAIL rr_out c=%0d got=%h want=%h", c, out_j(2), fr[exp_order[c]]); end
    end
    bus.in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [F-1:0] fx;
    logic [F-1:0] fy;
    fx = 82'h0_4444_0000_0000_0000_0044;
    fy = 82'h0_5555_0000_0000_0000_0055;
    bus.out_avail = 6'b101111;
    set_in(1, fx, 3'd5);
    #1;
    total++; if (bus.in_avail !== 6'b000010) begin bad++; $display("FAIL bp_first_avail got=%b want=%b", bus.in_avail, 6'b000010); end
    step();
    total++; if (bus.out_valid[4] !== 1'b1 || out_j(4) !== fx) begin bad++; $display("FAIL bp_load got=%b/%h want=1/%h", bus.out_valid[4], out_j(4), fx); end
    set_in(1, fy, 3'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.in_avail[1] !== 1'b0) begin bad++; $display("FAIL bp_stall_avail c=%0d got=%b want=0", c, bus.in_avail[1]); end
      step();
      total++; if (bus.out_valid[4] !== 1'b1 || out_j(4) !== fx) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h want=1/%h", c, bus.out_valid[4], out_j(4), fx); end
    end
    bus.out_avail = 6'h3F;
    #1;
    total++; if (bus.in_avail !== 6'b000010) begin bad++; $display("FAIL bp_release_avail got=%b want=%b", bus.in_avail, 6'b000010); end
    step();
    total++; if (bus.out_valid[4] !== 1'b1 || out_j(4) !== fy) begin bad++; $display("FAIL bp_drain_load got=%b/%h want=1/%h", bus.out_valid[4], out_j(4), fy); end
    bus.in_valid = '0;
  endtask

  task automatic test_drop();
    bus.out_avail = 6'h3F;
    set_in(3, 82'hDEAD, 3'd0);
    #1;
    total++; if (bus.in_avail !== 6'b001000) begin bad++; $display("FAIL drop0_avail got=%b want=%b", bus.in_avail, 6'b001000); end
    step();
    set_in(3, 82'hBEEF, 3'd7);
    #1;
    total++; if (bus.in_avail !== 6'b001000) begin bad++; $display("FAIL drop7_avail got=%b want=%b", bus.in_avail, 6'b001000); end
    step();
    bus.in_valid = '0;
    total++; if (bus.drop_cnt !== 16'd2) begin bad++; $display("FAIL drop_cnt2 got=%0d want=2", bus.drop_cnt); end
    total++; if (bus.out_valid !== 6'b0) begin bad++; $display("FAIL drop_vld got=%b want=%b", bus.out_valid, 6'b0); end
    for (int i = 0; i < MI; i++) set_in(i, 82'h0, 3'd0);
    step();
    total++; if (bus.drop_cnt !== 16'd8) begin bad++; $display("FAIL drop_cnt8 got=%0d want=8", bus.drop_cnt); end
    // 8 + 6*10923 = 65546 drops, beyond 2^16+5
    for (int c = 0; c < 10923; c++) step();
    total++; if (bus.drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL drop_sat got=%h want=%h", bus.drop_cnt, 16'hFFFF); end
    step();
    total++; if (bus.drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL drop_sat_hold got=%h want=%h", bus.drop_cnt, 16'hFFFF); end
    bus.in_valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_avail = 6'h00;
    for (int i = 0; i < 4; i++) set_in(i, 82'h200 + F'(i), RL'(i + 1));
    #1;
    total++; if (bus.in_avail !== 6'b001111) begin bad++; $display("FAIL mid_avail got=%b want=%b", bus.in_avail, 6'b001111); end
    step();
    total++; if (bus.out_valid !== 6'b001111) begin bad++; $display("FAIL mid_vld got=%b want=%b", bus.out_valid, 6'b001111); end
    rst = 1'b1;
    #1;
    total++; if (bus.in_avail !== 6'b0) begin bad++; $display("FAIL mid_rst_avail got=%b want=%b", bus.in_avail, 6'b0); end
    step();
    rst = 1'b0;
    bus.in_valid = '0;
    total++; if (bus.out_valid !== 6'b0) begin bad++; $display("FAIL mid_rst_vld got=%b want=%b", bus.out_valid, 6'b0); end
    total++; if (bus.drop_cnt !== 16'h0) begin bad++; $display("FAIL mid_rst_cnt got=%h want=0", bus.drop_cnt); end
    total++; if (bus.out !== '0) begin bad++; $display("FAIL mid_rst_out got=%h want=0", bus.out); end
    bus.out_avail = 6'h3F;
    for (int i = 0; i < MI; i++) set_in(i, 82'h300 + F'(i), 3'd2);
    #1;
    total++; if (bus.in_avail !== 6'b000001) begin bad++; $display("FAIL mid_ptr1 got=%b want=%b", bus.in_avail, 6'b000001); end
    step();
    total++; if (out_j(1) !== 82'h300) begin bad++; $display("FAIL mid_out1 got=%h want=%h", out_j(1), 82'h300); end
    for (int i = 0; i < MI; i++) set_in(i, 82'h400 + F'(i), 3'd4);
    #1;
    total++; if (bus.in_avail !== 6'b000001) begin bad++; $display("FAIL mid_ptr3 got=%b want=%b", bus.in_avail, 6'b000001); end
    step();
    bus.in_valid = '0;
    step();
  endtask

  task automatic test_reduce();
    logic [F-1:0] f0, f1, f2, f4, exp0;
    rst = 1'b1;
    bus.in_valid = '0;
    step();
    rst = 1'b0;
    bus.out_avail = 6'h3F;
    f0 = {1'b1, 17'h1ABCD, 64'd5};
    f1 = {1'b1, 17'h01111, 64'd7};
    f4 = {1'b1, 17'h02222, 64'hFFFF_FFFF_FFFF_FFFF};
    f2 = {1'b0, 17'h03333, 64'd100};
    set_in(0, f0, 3'd2);
    set_in(1, f1, 3'd2);
    set_in(2, f2, 3'd2);
    set_in(4, f4, 3'd2);
`ifdef COLLECTIVE_REDUCE_EN
    exp0 = {1'b1, 17'h1ABCD, 64'd11};
    #1;
    total++; if (bus.in_avail !== 6'b010011) begin bad++; $display("FAIL red_avail got=%b want=%b", bus.in_avail, 6'b010011); end
    step();
    total++; if (out_j(1) !== exp0) begin bad++; $display("FAIL red_out got=%h want=%h", out_j(1), exp0); end
    bus.in_valid = 6'b000100;
    #1;
    total++; if (bus.in_avail !== 6'b000100) begin bad++; $display("FAIL red_plain_avail got=%b want=%b", bus.in_avail, 6'b000100); end
    step();
    total++; if (out_j(1) !== f2) begin bad++; $display("FAIL red_plain_out got=%h want=%h", out_j(1), f2); end
`else
    exp0 = f0;
    #1;
    total++; if (bus.in_avail !== 6'b000001) begin bad++; $display("FAIL flag_avail got=%b want=%b", bus.in_avail, 6'b000001); end
    step();
    total++; if (out_j(1) !== exp0) begin bad++; $display("FAIL flag_out got=%h want=%h", out_j(1), exp0); end
    #1;
    total++; if (bus.in_avail !== 6'b000010) begin bad++; $display("FAIL flag_next_avail got=%b want=%b", bus.in_avail, 6'b000010); end
    step();
    total++; if (out_j(1) !== f1) begin bad++; $display("FAIL flag_next_out got=%h want=%h", out_j(1), f1); end
`endif
    bus.in_valid = '0;
    step();
  endtask

  initial begin
    bus.in        = '0;
    bus.route_in  = '0;
    bus.in_valid  = '0;
    bus.out_avail = '0;
    step();
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_reduce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/collective_switch.md
# collective_switch

Parametrised crossbar stage of the collective router. It accepts up to M_IN routed flits per cycle and steers each one to one of N_OUT direction outputs. Each output has its own round-robin arbiter and a one-entry output register. With the compile option below, an output can also combine reduce-flagged flits from several inputs into one summed flit. It replaces the single-direction switch and drives all six torus directions (xpos, ypos, zpos, xneg, yneg, zneg).

## Interface
- FLIT_SIZE, 82, flit width in bits
- M_IN, 6, number of input ports
- N_OUT, 6, number of output ports (1..6)
- ROUTE_LEN, 3, route code width per input
- DATA_W, 64, reduction operand width, taken from flit[DATA_W-1:0]; must be less than FLIT_SIZE
- CNT_W, 16, drop counter width

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in  in  M_IN*FLIT_SIZE  input flits; port i is in[i*FLIT_SIZE +: FLIT_SIZE]
- route_in  in  M_IN*ROUTE_LEN  route code per input: 1=xpos, 2=ypos, 3=zpos, 4=xneg, 5=yneg, 6=zneg
- in_valid  in  M_IN  input flit present
- in_avail  out  M_IN  grant; input i is consumed this cycle iff in_valid[i] & in_avail[i]
- out_avail  in  N_OUT  downstream can accept; an output flit leaves iff out_valid[j] & out_avail[j]
- out_valid  out  N_OUT  output register j holds a flit
- out  out  N_OUT*FLIT_SIZE  output flits; port j is out[j*FLIT_SIZE +: FLIT_SIZE]
- drop_cnt  out  CNT_W  count of flits dropped for an illegal route

## Operation
- Input i requests output j = route_in[i]-1 when in_valid[i] is high and 1 ≤ route_in[i] ≤ N_OUT.
- Illegal route (code 0, 7, or greater than N_OUT) with in_valid high:
  - in_avail[i] is 1 that cycle and the flit is discarded.
  - drop_cnt increments by the number of such inputs, saturating at all-ones.
- Output j may load when its register is empty, or full with out_avail[j]=1. The latter case drains and loads in the same cycle.
- If output j cannot load, no input requesting j is granted.
- Round-robin per output:
  - Pointer p_j starts at 0 after reset.
  - The winner is the first requester found scanning p_j, p_j+1, … modulo M_IN.
  - After a grant, p_j becomes winner+1 modulo M_IN. The pointer is unchanged when there is no grant.
- in_avail is combinational from in_valid, route_in, out_avail and the register state. No other input path feeds it.
- An input is granted at most once per cycle. Each output is independent, so up to N_OUT flits move per cycle.
- Output register holds the flit until it is drained, and the flit is stable while out_valid=1 and out_avail=0.

## Timing
- Reset values: out_valid=0, out=0, in_avail=0 during rst, all p_j=0, drop_cnt=0.
- Reset mid-operation discards every held flit with no partial output.
- Latency: a flit accepted in cycle t is presented with out_valid=1 in cycle t+1.
- Throughput: 1 flit per output per cycle under continuous out_avail=1.
- A zero-bubble drain-and-load is required: out_valid stays 1 across back-to-back flits.
- drop_cnt updates in cycle t+1 for drops in cycle t.

## Configuration
- Macro: COLLECTIVE_REDUCE_EN.
- Defined:
  - flit[FLIT_SIZE-1] is the reduce flag.
  - If the round-robin winner for output j has the flag set, every requester of j with the flag set is granted in the same cycle. Requesters of j without the flag wait.
  - The output flit is taken from the winner, with bits [DATA_W-1:0] replaced by the sum of the granted operands modulo 2^DATA_W.
  - p_j becomes winner+1.
  - If the winner's flag is clear, the output forwards normally.
- Undefined: the flag bit is ordinary payload, no adders are built, and only one input is granted per output.

## Test plan
- Reset, then input 0 sends flit 0x...AA with route 1 and out_avail=6'h3F → in_avail[0]=1 in cycle 0; out_valid[0]=1 with out[81:0]=0x...AA in cycle 1; all other outputs stay 0.
- Inputs 0, 2 and 5 all send route 3 continuously with out_avail[2]=1 → grants in the order 0, 2, 5, 0, 2, 5 with one flit per cycle and out_valid[2] held at 1.
- Output 4 is full and out_avail[4]=0 for 3 cycles while input 1 requests route 5 → in_avail[1]=0 and out[4] stays stable. Raising out_avail[4] → drain and load in the same cycle.
- Input 3 sends routes 0, then 7, with N_OUT=6 → both flits consumed, no out_valid, drop_cnt=2. Drive 2^CNT_W+5 drops → drop_cnt holds at 16'hFFFF.
- With COLLECTIVE_REDUCE_EN defined, inputs 0, 1 and 4 send reduce-flagged route 2 with operands 5, 7 and 2^64-1 → all three granted in one cycle; out[1] data is 11 and the upper bits come from input 0.
- Assert rst while 4 outputs are valid → next cycle all out_valid=0 and drop_cnt=0, and the next grant to each output goes to input 0.
